// File: rtl/det_event_logger_pkg.sv
// Shared constants and types for the detection event logger.
// Holds the default FIFO depth and timestamp width used by det_event_logger
// and evt_fifo, plus the pointer type that matches the default depth
// (one extra MSB beyond the index bits to tell full from empty).
package det_event_logger_pkg;

    localparam int unsigned DET_LOG_DEPTH = 4;
    localparam int unsigned DET_LOG_TS_W  = 16;
    localparam int unsigned DET_LOG_PTR_W = $clog2(DET_LOG_DEPTH) + 1;

    typedef logic [DET_LOG_PTR_W-1:0] det_ptr_t;

endpackage

// File: rtl/det_event_logger_evt_fifo.sv
// evt_fifo: small timestamp FIFO for the detection event logger.
// Pointers carry one wrap bit above the index, so equal pointers mean empty
// and pointers differing only in the MSB mean full. The head entry is kept
// in a register so the consumer sees stable data with no read-port timing.
// A push and a pop in the same cycle are both accepted even when full.
module evt_fifo
    import det_event_logger_pkg::*;
#(
    parameter int unsigned DEPTH = DET_LOG_DEPTH,
    parameter int unsigned W     = DET_LOG_TS_W
) (
    input  logic         clock_i,
    input  logic         areset_ni,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_ptr_nxt;
    logic [AW:0]  rd_ptr_nxt;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;
    logic         empty_nxt;
    logic         push_to_head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_ptr_nxt   = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
    assign rd_ptr_nxt   = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
    assign empty_nxt    = (wr_ptr_nxt == rd_ptr_nxt);
    assign push_to_head = do_push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]);

    // Pointer registers; a clear empties the FIFO without touching storage.
    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Storage array; contents are don't-care until a pointer covers them.
    always_ff @(posedge clock_i) begin
        if (do_push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Registered head: bypass the incoming word when it lands at the next read slot.
    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            head_data <= '0;
        end else if (clear || empty_nxt) begin
            head_data <= '0;
        end else if (push_to_head) begin
            head_data <= push_data;
        end else begin
            head_data <= mem[rd_ptr_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/det_event_logger.sv
// det_event_logger: timestamps detection pulses and queues them for a consumer.
// A free-running timestamp is captured into evt_fifo on every det_i pulse.
// Drops on a full FIFO raise a sticky overflow flag; det_cnt_o counts every
// detection (kept or dropped) and saturates. clear_i flushes everything and
// wins over a simultaneous detection or pop.
// Optional feature: define DET_LOG_OVF_CNT_EN to add ovf_cnt_o, a saturating
// count of dropped detections.
module det_event_logger
    import det_event_logger_pkg::*;
#(
    parameter int unsigned DEPTH = DET_LOG_DEPTH,
    parameter int unsigned TS_W  = DET_LOG_TS_W
) (
    input  logic            clock_i,
    input  logic            areset_ni,
    input  logic            det_i,
    input  logic            clear_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [TS_W-1:0] evt_ts_o,
    output logic [15:0]     det_cnt_o,
`ifdef DET_LOG_OVF_CNT_EN
    output logic            overflow_o,
    output logic [7:0]      ovf_cnt_o
`else
    output logic            overflow_o
`endif
);

    logic [TS_W-1:0] ts_q;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            drop;

    assign evt_valid_o = !fifo_empty;
    assign pop         = evt_valid_o && evt_ready_i;
    assign drop        = det_i && fifo_full && !pop;

    evt_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W)
    ) u_evt_fifo (
        .clock_i   (clock_i),
        .areset_ni (areset_ni),
        .clear     (clear_i),
        .push      (det_i),
        .pop       (pop),
        .push_data (ts_q),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (evt_ts_o)
    );

    // Free-running timestamp, wraps naturally at 2^TS_W.
    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            ts_q <= '0;
        end else if (clear_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Total detection count, stops at all-ones.
    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            det_cnt_o <= '0;
        end else if (clear_i) begin
            det_cnt_o <= '0;
        end else if (det_i && (det_cnt_o != 16'hFFFF)) begin
            det_cnt_o <= det_cnt_o + 16'd1;
        end
    end

    // Sticky flag raised by any detection that found the FIFO full with no pop.
    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            overflow_o <= 1'b0;
        end else if (drop) begin
            overflow_o <= 1'b1;
        end
    end

`ifdef DET_LOG_OVF_CNT_EN
    // Dropped-detection count, stops at all-ones.
    always_ff @(posedge clock_i or negedge areset_ni) begin
        if (!areset_ni) begin
            ovf_cnt_o <= '0;
        end else if (clear_i) begin
            ovf_cnt_o <= '0;
        end else if (drop && (ovf_cnt_o != 8'hFF)) begin
            ovf_cnt_o <= ovf_cnt_o + 8'd1;
        end
    end
`endif

endmodule
